// File: rtl/lc3_pkg.sv
// lc3_pkg: shared state enum, opcode values and datapath select encodings
// for the LC-3 control unit.
package lc3_pkg;

  typedef enum logic [5:0] {
    S_HALTED, S_18, S_33, S_35, S_STEP, S_32,
    S_1, S_5, S_9, S_0, S_22, S_12, S_4, S_20, S_21,
    S_2, S_6, S_14, S_3, S_7, S_10, S_11, S_24, S_26,
    S_25, S_27, S_23, S_16, S_15, S_28, S_29, S_30, S_PAUSE
  } state_t;

  localparam logic [3:0] OP_BR   = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_LD   = 4'd2;
  localparam logic [3:0] OP_ST   = 4'd3;
  localparam logic [3:0] OP_JSR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_LDR  = 4'd6;
  localparam logic [3:0] OP_STR  = 4'd7;
  localparam logic [3:0] OP_RTI  = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_LDI  = 4'd10;
  localparam logic [3:0] OP_STI  = 4'd11;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_RES  = 4'd13;
  localparam logic [3:0] OP_LEA  = 4'd14;
  localparam logic [3:0] OP_TRAP = 4'd15;

  localparam logic [1:0] BUS_PC   = 2'b00;
  localparam logic [1:0] BUS_MDR  = 2'b01;
  localparam logic [1:0] BUS_ALU  = 2'b10;
  localparam logic [1:0] BUS_ADDR = 2'b11;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_BUS  = 2'b01;
  localparam logic [1:0] PC_ADDR = 2'b10;

  localparam logic [1:0] A2_ZERO  = 2'b00;
  localparam logic [1:0] A2_OFF6  = 2'b01;
  localparam logic [1:0] A2_OFF9  = 2'b10;
  localparam logic [1:0] A2_OFF11 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_AND   = 2'b01;
  localparam logic [1:0] ALU_NOT   = 2'b10;
  localparam logic [1:0] ALU_PASSA = 2'b11;

  localparam logic [1:0] DR_IR  = 2'b00;
  localparam logic [1:0] DR_R7  = 2'b01;
  localparam logic [1:0] SR1_HI = 2'b00;
  localparam logic [1:0] SR1_LO = 2'b01;

  // States that hold a memory strobe low and run the wait-state counter
  function automatic logic is_mem_access(input state_t s);
    return (s == S_33) || (s == S_24) || (s == S_25) || (s == S_29) || (s == S_16);
  endfunction

endpackage

// File: rtl/lc3_mem_wait.sv
// lc3_mem_wait: wait-state counter shared by every memory access state.
// Counts 0..MEM_WAIT-1 while active; done marks the final cycle of an access.
module lc3_mem_wait #(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  output logic done
);

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT - 1);

  logic [CW-1:0] count;

  assign done = active && (count == LAST);

  // Advance during an access, return to zero on the final cycle or when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (active && !done) begin
      count <= count + 1'b1;
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// lc3_ctrl_fsm: LC-3 control unit driving datapath loads, mux selects and
// SRAM strobes. Optional macro LC3_STEP_PAUSE_EN adds a single-step hold
// state after each instruction fetch, released by Continue.
module lc3_ctrl_fsm
  import lc3_pkg::*;
#(
  parameter int         MEM_WAIT = 2,
  parameter logic [3:0] PAUSE_OP = 4'b1101
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic [1:0] busMux,
  output logic [1:0] PCMUX,
  output logic [1:0] DRMUX,
  output logic [1:0] SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic       MIO_EN,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE,
  output logic       Mem_UB,
  output logic       Mem_LB,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  state_t state, next_state;
  logic   mem_active, mem_done;

  assign mem_active = is_mem_access(state);
  assign Mem_CE = 1'b0;
  assign Mem_UB = 1'b0;
  assign Mem_LB = 1'b0;

  lc3_mem_wait #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .active (mem_active),
    .done   (mem_done)
  );

  // State register; reset parks the machine in HALTED from any state
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_HALTED;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and all control outputs from state and wait counter
  always_comb begin
    next_state = state;
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0;
    busMux = BUS_PC; PCMUX = PC_INC; DRMUX = DR_IR; SR1MUX = SR1_HI;
    SR2MUX = 1'b0; ADDR1MUX = 1'b0; MIO_EN = 1'b0;
    ADDR2MUX = A2_ZERO; ALUK = ALU_ADD;
    Mem_OE = 1'b1; Mem_WE = 1'b1;
    case (state)
      S_HALTED: if (Run) next_state = S_18;
      S_18: begin
        busMux = BUS_PC; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = PC_INC;
        next_state = S_33;
      end
      S_33, S_24, S_25, S_29: begin
        Mem_OE = 1'b0; MIO_EN = 1'b1;
        if (mem_done) begin
          LD_MDR = 1'b1;
          case (state)
            S_33:    next_state = S_35;
            S_24:    next_state = S_26;
            S_25:    next_state = S_27;
            default: next_state = S_30;
          endcase
        end
      end
      S_35: begin
        busMux = BUS_MDR; LD_IR = 1'b1;
`ifdef LC3_STEP_PAUSE_EN
        next_state = S_STEP;
`else
        next_state = S_32;
`endif
      end
      S_STEP: if (Continue) next_state = S_32;
      S_32: begin
        LD_BEN = 1'b1;
        if (Opcode == PAUSE_OP) begin
          next_state = S_PAUSE;
        end else begin
          case (Opcode)
            OP_BR:   next_state = S_0;
            OP_ADD:  next_state = S_1;
            OP_LD:   next_state = S_2;
            OP_ST:   next_state = S_3;
            OP_JSR:  next_state = S_4;
            OP_AND:  next_state = S_5;
            OP_LDR:  next_state = S_6;
            OP_STR:  next_state = S_7;
            OP_RTI:  next_state = S_18;
            OP_NOT:  next_state = S_9;
            OP_LDI:  next_state = S_10;
            OP_STI:  next_state = S_11;
            OP_JMP:  next_state = S_12;
            OP_RES:  next_state = S_18;
            OP_LEA:  next_state = S_14;
            OP_TRAP: next_state = S_15;
            default: next_state = S_18;
          endcase
        end
      end
      S_1, S_5, S_9: begin
        busMux = BUS_ALU; LD_REG = 1'b1; LD_CC = 1'b1; SR1MUX = SR1_LO;
        if (state == S_1) begin
          ALUK = ALU_ADD; SR2MUX = IR_5;
        end else if (state == S_5) begin
          ALUK = ALU_AND; SR2MUX = IR_5;
        end else begin
          ALUK = ALU_NOT;
        end
        next_state = S_18;
      end
      S_0: next_state = BEN ? S_22 : S_18;
      S_22: begin
        ADDR1MUX = 1'b0; ADDR2MUX = A2_OFF9; PCMUX = PC_ADDR; LD_PC = 1'b1;
        next_state = S_18;
      end
      S_12, S_20: begin
        SR1MUX = SR1_LO; ADDR1MUX = 1'b1; ADDR2MUX = A2_ZERO;
        PCMUX = PC_ADDR; LD_PC = 1'b1;
        next_state = S_18;
      end
      S_4: begin
        busMux = BUS_PC; DRMUX = DR_R7; LD_REG = 1'b1;
        next_state = IR_11 ? S_21 : S_20;
      end
      S_21: begin
        ADDR1MUX = 1'b0; ADDR2MUX = A2_OFF11; PCMUX = PC_ADDR; LD_PC = 1'b1;
        next_state = S_18;
      end
      S_2, S_3, S_10, S_11: begin
        busMux = BUS_ADDR; ADDR1MUX = 1'b0; ADDR2MUX = A2_OFF9; LD_MAR = 1'b1;
        case (state)
          S_2:     next_state = S_25;
          S_3:     next_state = S_23;
          default: next_state = S_24;
        endcase
      end
      S_6, S_7: begin
        busMux = BUS_ADDR; SR1MUX = SR1_LO; ADDR1MUX = 1'b1;
        ADDR2MUX = A2_OFF6; LD_MAR = 1'b1;
        next_state = (state == S_6) ? S_25 : S_23;
      end
      S_14: begin
        busMux = BUS_ADDR; ADDR1MUX = 1'b0; ADDR2MUX = A2_OFF9;
        LD_REG = 1'b1; LD_CC = 1'b1;
        next_state = S_18;
      end
      S_26: begin
        busMux = BUS_MDR; LD_MAR = 1'b1;
        next_state = (Opcode == OP_STI) ? S_23 : S_25;
      end
      S_27: begin
        busMux = BUS_MDR; LD_REG = 1'b1; LD_CC = 1'b1;
        next_state = S_18;
      end
      S_23: begin
        SR1MUX = SR1_HI; ALUK = ALU_PASSA; busMux = BUS_ALU;
        MIO_EN = 1'b0; LD_MDR = 1'b1;
        next_state = S_16;
      end
      S_16: begin
        Mem_WE = 1'b0;
        if (mem_done) next_state = S_18;
      end
      S_15: begin
        busMux = BUS_ADDR; ADDR1MUX = 1'b0; ADDR2MUX = A2_ZERO; LD_MAR = 1'b1;
        next_state = S_28;
      end
      S_28: begin
        busMux = BUS_PC; DRMUX = DR_R7; LD_REG = 1'b1;
        next_state = S_29;
      end
      S_30: begin
        busMux = BUS_MDR; PCMUX = PC_BUS; LD_PC = 1'b1;
        next_state = S_18;
      end
      S_PAUSE: if (Continue) next_state = S_18;
      default: next_state = S_HALTED;
    endcase
  end

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// tb_lc3_ctrl_fsm: directed timing/reset checks, then random instruction
// streams scored against an instruction-level micro-op model.
module tb_lc3_ctrl_fsm;

  localparam int MW = 3;
  localparam int N_INSTR = 200;
  localparam int X = -1;
  localparam logic [6:0] L_MAR = 7'b1000000;
  localparam logic [6:0] L_MDR = 7'b0100000;
  localparam logic [6:0] L_IR  = 7'b0010000;
  localparam logic [6:0] L_BEN = 7'b0001000;
  localparam logic [6:0] L_CC  = 7'b0000100;
  localparam logic [6:0] L_REG = 7'b0000010;
  localparam logic [6:0] L_PC  = 7'b0000001;
  localparam logic [6:0] L_NONE = 7'b0000000;
  localparam logic [23:0] IDLE = 24'h000003;
`ifdef LC3_STEP_PAUSE_EN
  localparam int DIRECT_LEN = MW + 6;
  localparam int EXP_REG_CYC = MW + 5;
`else
  localparam int DIRECT_LEN = MW + 5;
  localparam int EXP_REG_CYC = MW + 4;
`endif

  typedef struct packed {
    logic [23:0] val;
    logic [23:0] care;
  } rec_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic Run = 1'b0;
  logic Continue = 1'b0;
  logic [3:0] Opcode = 4'd0;
  logic IR_5 = 1'b0;
  logic IR_11 = 1'b0;
  logic BEN = 1'b0;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
  logic [1:0] busMux, PCMUX, DRMUX, SR1MUX, ADDR2MUX, ALUK;
  logic SR2MUX, ADDR1MUX, MIO_EN;
  logic Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
  logic [23:0] word;

  rec_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  lc3_ctrl_fsm #(.MEM_WAIT(MW), .PAUSE_OP(4'b1101)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC),
    .busMux(busMux), .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX),
    .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .MIO_EN(MIO_EN),
    .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  assign word = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
                 busMux, PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN,
                 ADDR2MUX, ALUK, Mem_OE, Mem_WE};

  always #5 Clk = ~Clk;

  // One expected control word; a field argument of X means "not constrained"
  function automatic rec_t mk(input logic [6:0] lds, input logic oe, input logic we,
                              input int bus, input int pcm, input int drm,
                              input int sr1, input int sr2, input int a1,
                              input int mio, input int a2, input int aluk);
    rec_t r;
    r.val = '0;
    r.care = '0;
    r.val[23:17] = lds;  r.care[23:17] = '1;
    r.val[1] = oe;       r.val[0] = we;  r.care[1:0] = 2'b11;
    if (bus  >= 0) begin r.val[16:15] = 2'(bus);  r.care[16:15] = 2'b11; end
    if (pcm  >= 0) begin r.val[14:13] = 2'(pcm);  r.care[14:13] = 2'b11; end
    if (drm  >= 0) begin r.val[12:11] = 2'(drm);  r.care[12:11] = 2'b11; end
    if (sr1  >= 0) begin r.val[10:9]  = 2'(sr1);  r.care[10:9]  = 2'b11; end
    if (sr2  >= 0) begin r.val[8]     = 1'(sr2);  r.care[8]     = 1'b1;  end
    if (a1   >= 0) begin r.val[7]     = 1'(a1);   r.care[7]     = 1'b1;  end
    if (mio  >= 0) begin r.val[6]     = 1'(mio);  r.care[6]     = 1'b1;  end
    if (a2   >= 0) begin r.val[5:4]   = 2'(a2);   r.care[5:4]   = 2'b11; end
    if (aluk >= 0) begin r.val[3:2]   = 2'(aluk); r.care[3:2]   = 2'b11; end
    return r;
  endfunction

  task automatic push_read();
    for (int i = 0; i < MW; i++)
      sb.push_back(mk((i == MW - 1) ? L_MDR : L_NONE, 1'b0, 1'b1, X, X, X, X, X, X, 1, X, X));
  endtask

  task automatic push_write();
    for (int i = 0; i < MW; i++)
      sb.push_back(mk(L_NONE, 1'b1, 1'b0, X, X, X, X, X, X, X, X, X));
  endtask

  task automatic push_fetch();
    sb.push_back(mk(L_MAR | L_PC, 1'b1, 1'b1, 0, 0, X, X, X, X, X, X, X));
    push_read();
    sb.push_back(mk(L_IR, 1'b1, 1'b1, 1, X, X, X, X, X, X, X, X));
  endtask

  // Micro-op sequence of one instruction from decode through completion
  task automatic apply_stimulus(input int op, input bit ir5, input bit ir11, input bit ben);
    sb.push_back(mk(L_BEN, 1'b1, 1'b1, X, X, X, X, X, X, X, X, X));
    case (op)
      1, 5, 9: sb.push_back(mk(L_REG | L_CC, 1'b1, 1'b1, 2, X, X, 1,
                               (op == 9) ? X : int'(ir5), X, X, X,
                               (op == 1) ? 0 : ((op == 5) ? 1 : 2)));
      0: if (ben) sb.push_back(mk(L_PC, 1'b1, 1'b1, X, 2, X, X, X, X, X, 2, X));
      12: sb.push_back(mk(L_PC, 1'b1, 1'b1, X, 2, X, 1, X, 1, X, 0, X));
      4: begin
        sb.push_back(mk(L_REG, 1'b1, 1'b1, 0, X, 1, X, X, X, X, X, X));
        if (ir11) sb.push_back(mk(L_PC, 1'b1, 1'b1, X, 2, X, X, X, X, X, 3, X));
        else      sb.push_back(mk(L_PC, 1'b1, 1'b1, X, 2, X, 1, X, 1, X, 0, X));
      end
      14: sb.push_back(mk(L_REG | L_CC, 1'b1, 1'b1, 3, X, X, X, X, 0, X, 2, X));
      2, 3, 10, 11: sb.push_back(mk(L_MAR, 1'b1, 1'b1, 3, X, X, X, X, 0, X, 2, X));
      6, 7: sb.push_back(mk(L_MAR, 1'b1, 1'b1, 3, X, X, 1, X, 1, X, 1, X));
      15: begin
        sb.push_back(mk(L_MAR, 1'b1, 1'b1, 3, X, X, X, X, X, X, 0, X));
        sb.push_back(mk(L_REG, 1'b1, 1'b1, 0, X, 1, X, X, X, X, X, X));
        push_read();
        sb.push_back(mk(L_PC, 1'b1, 1'b1, 1, 1, X, X, X, X, X, X, X));
      end
      default: ;
    endcase
    if (op == 10 || op == 11) begin
      push_read();
      sb.push_back(mk(L_MAR, 1'b1, 1'b1, 1, X, X, X, X, X, X, X, X));
    end
    if (op == 2 || op == 6 || op == 10) begin
      push_read();
      sb.push_back(mk(L_REG | L_CC, 1'b1, 1'b1, 1, X, X, X, X, X, X, X, X));
    end
    if (op == 3 || op == 7 || op == 11) begin
      sb.push_back(mk(L_MDR, 1'b1, 1'b1, 2, X, X, 0, X, X, 0, X, 3));
      push_write();
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ir(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge Clk);
      if (LD_IR === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic step_release();
`ifdef LC3_STEP_PAUSE_EN
    repeat (10) @(negedge Clk);
    Continue = 1'b1;
    @(negedge Clk);
    Continue = 1'b0;
`endif
  endtask

  // Monitor: every non-idle control word must match the next expected micro-op
  always @(negedge Clk) begin : monitor
    rec_t r;
    if (mon_en && Reset_n && (word !== IDLE)) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL unexpected_ctrl actual=%h expected=none", word);
      end else begin
        r = sb.pop_front();
        if (((word ^ r.val) & r.care) !== 24'h0) begin
          n_bad++;
          $display("[TB] FAIL ctrl_word actual=%h expected=%h care=%h", word, r.val, r.care);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int op;
    int oe_low, ir_cyc, reg_cyc;
    bit ok;
    bit ir5, ir11, ben;

    // Reset state
    #12;
    check_output("reset_idle", word, IDLE);
    check_output("ce_ub_lb_tied", {Mem_CE, Mem_UB, Mem_LB}, 0);

    // Directed ADD through one fetch: OE low MW cycles, LD_IR then LD_REG+LD_CC
    Opcode = 4'd1;
    Continue = 1'b1;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    Run = 1'b1;
    oe_low = 0; ir_cyc = 0; reg_cyc = 0;
    for (int c = 1; c <= DIRECT_LEN; c++) begin
      @(negedge Clk);
      Run = 1'b0;
      if (Mem_OE == 1'b0) oe_low++;
      if (LD_IR && ir_cyc == 0) ir_cyc = c;
      if (LD_REG && LD_CC && reg_cyc == 0) reg_cyc = c;
    end
    check_output("fetch_oe_low_cycles", oe_low, MW);
    check_output("ld_ir_cycle", ir_cyc, MW + 2);
    check_output("ld_reg_cc_cycle", reg_cyc, EXP_REG_CYC);

    // Reset asserted during the fetch read
    @(posedge Clk);
    #2;
    check_output("s33_oe_low", Mem_OE, 0);
    Reset_n = 1'b0;
    #1;
    check_output("reset_in_s33", word, IDLE);
    @(negedge Clk);
    Reset_n = 1'b1;
    Continue = 1'b0;
    repeat (3) @(negedge Clk);
    check_output("halted_holds", word, IDLE);

    // Random instruction stream, checked by the monitor
    mon_en = 1'b1;
    push_fetch();
    Run = 1'b1;
    @(negedge Clk);
    Run = 1'b0;
    for (int k = 0; k <= N_INSTR; k++) begin
      wait_ir(ok);
      if (!ok) begin
        check_output("wait_ld_ir_timeout", 1, 0);
        break;
      end
      op = (k == N_INSTR) ? 13 : int'($urandom_range(0, 15));
      ir5 = 1'($urandom);
      ir11 = 1'($urandom);
      ben = 1'($urandom);
      Continue = 1'b0;
      Opcode = 4'(op);
      IR_5 = ir5;
      IR_11 = ir11;
      BEN = ben;
      apply_stimulus(op, ir5, ir11, ben);
      if (k < N_INSTR && op != 13) push_fetch();
      step_release();
      if (op == 13 && k < N_INSTR) begin
        push_fetch();
        repeat ($urandom_range(3, 8)) @(negedge Clk);
        Continue = 1'b1;
      end
    end

    // Final instruction parks in PAUSE: nothing further may appear
    repeat (20) @(negedge Clk);
    check_output("queue_drained", sb.size(), 0);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_ctrl_fsm.md
# lc3_ctrl_fsm

Parametrised LC-3 control unit and successor to the lab-6 ISDU: decodes the full LC-3 opcode set (ALU, branch, JMP/JSR/JSRR, LD/LDR/LDI, ST/STR/STI, LEA, TRAP, PAUSE) instead of the ALU/branch subset. Sits between the IR/BEN/CC datapath and the SRAM interface. Memory access timing is set by a wait-state counter rather than fixed duplicated states. Drives every datapath load, mux select and memory strobe.

## Interface
- MEM_WAIT, 2, cycles Mem_OE/Mem_WE held low per access (≥1)
- PAUSE_OP, 4'b1101, opcode that halts execution until Continue
- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  reset, asynchronous, active-low
- Run, Continue  in  1 each  start from halted; release from pause (level, sampled)
- Opcode  in  4  IR[15:12]
- IR_5, IR_11  in  1 each  immediate select; JSR (1) vs JSRR (0)
- BEN  in  1  registered branch-enable
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC  out  1 each  register loads
- busMux  out  2  00 PC, 01 MDR, 10 ALU, 11 address adder
- PCMUX  out  2  00 PC+1, 01 bus, 10 adder
- DRMUX, SR1MUX  out  2 each  DR: 00 IR[11:9], 01 R7; SR1: 00 IR[11:9], 01 IR[8:6]
- SR2MUX, ADDR1MUX, MIO_EN  out  1 each  IR_5; 0 PC/1 SR1; MDR source 1 memory/0 bus
- ADDR2MUX, ALUK  out  2 each  00 zero/01 off6/10 off9/11 off11; 00 ADD/01 AND/10 NOT/11 PASSA
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  active-low strobes; CE/UB/LB tied 0

## Operation
- Reset (async, any state): state HALTED, wait counter 0, all LD_*/mux outputs 0, Mem_OE=Mem_WE=1.
- HALTED→S18 when Run=1; otherwise holds. Run ignored in all other states.
- S18: busMux=00, LD_MAR, LD_PC, PCMUX=00. S33: Mem_OE=0, MIO_EN=1; counter counts 0..MEM_WAIT-1, LD_MDR on final count, then S35. S35: busMux=01, LD_IR. S32: LD_BEN; dispatch on Opcode.
- ADD/AND/NOT (1/5/9): ALUK per op, busMux=10, LD_REG, LD_CC, SR1MUX=01 → S18.
- BR (0): S0 → S22 if BEN (ADDR2MUX=10, PCMUX=10, LD_PC) else S18.
- JMP (12): SR1MUX=01, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC.
- JSR (4): S4 busMux=00, DRMUX=01, LD_REG; IR_11=1 → S21 (ADDR2MUX=11, PCMUX=10), else S20 (as JMP).
- LD/LDR/LEA/ST/STR (2/6/14/3/7): address phase busMux=11, LD_MAR (LEA: LD_REG, LD_CC, done). Loads → S25 (read, counter) → S27 (busMux=01, LD_REG, LD_CC). Stores → S23 (SR1MUX=00, ALUK=11, busMux=10, MIO_EN=0, LD_MDR) → S16 (Mem_WE=0 for MEM_WAIT cycles).
- LDI/STI (10/11): extra read S24 then S26 (busMux=01, LD_MAR) before S25/S23.
- TRAP (15): S15 busMux=11 with zext trapvect via ADDR2MUX=00 path, LD_MAR; R7←PC; read; PC←MDR.
- PAUSE_OP: PAUSE state, all loads 0; Continue=1 → S18. Opcode 8 (RTI, unsupported) → S18.

## Timing
- Fetch = 1 + MEM_WAIT + 1 cycles; decode 1 cycle; ADD end-to-end = MEM_WAIT+4 cycles.
- Each memory access occupies exactly MEM_WAIT cycles with strobe low; counter reset to 0 on every access exit.
- LD_REG and LD_CC asserted in the same cycle for ADD/AND/NOT/LD/LDR/LDI/LEA.
- Outputs are combinational from state and counter only; no output depends combinationally on Run/Continue.
- Reset mid-write deasserts Mem_WE immediately (async).

## Configuration
- LC3_STEP_PAUSE_EN: defined → extra STEP state after S35 holds until Continue=1, exposing each IR for single-step debug. Undefined → S35 goes directly to S32; PAUSE_OP still honoured.

## Structure
- Package lc3_pkg: state enum, opcode localparams, busMux/PCMUX/ADDR2MUX/ALUK encodings.
- Sub-module lc3_mem_wait: MEM_WAIT counter with start/done, shared by all access states.

## Test plan
- Reset_n=0 in S33 → next observe: HALTED, Mem_OE=1, LD_* all 0.
- MEM_WAIT=3, Run=1, Opcode=0001 → Mem_OE low exactly 3 cycles, LD_IR at cycle 5, LD_REG+LD_CC at cycle 7.
- Opcode=0000, BEN=0 → S0→S18 with no LD_PC; BEN=1 → S22 with PCMUX=10, LD_PC=1.
- Opcode=1011 (STI) → two read accesses, busMux=01 LD_MAR, then Mem_WE low MEM_WAIT cycles.
- Opcode=0100, IR_11=0 → DRMUX=01 LD_REG, then PCMUX=10 ADDR1MUX=1.
- With LC3_STEP_PAUSE_EN, Continue=0 for 10 cycles → FSM holds, no loads; Continue=1 → S32.
